// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the push-button conditioning path.
//   db_state_e            : debounce FSM state encoding (2 bits)
//   STABLE_CYCLES_DEFAULT : hold time in clk cycles (10 ms at 100 MHz)
// ---------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,  // settled released, db_out=0
    WAIT1 = 2'b01,  // candidate press, db_out=0
    ONE   = 2'b10,  // settled pressed, db_out=1
    WAIT0 = 2'b11   // candidate release, db_out=1
  } db_state_e;

  localparam int unsigned STABLE_CYCLES_DEFAULT = 1_000_000;

endpackage : debounce_pkg

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchronizer for asynchronous switch inputs.
// Ports:
//   clk : destination clock
//   rst : asynchronous, active-high reset (both flops clear to 0)
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule : sync_2ff

// File: rtl/debounce_pulse.sv
// ---------------------------------------------------------------------------
// debounce_pulse
// Conditions one raw push-button: two-flop synchronizer, debounce FSM and a
// one-shot strobe on each accepted press.
// Parameters:
//   STABLE_CYCLES : cycles the synchronized input must hold a new value
//                   before it is accepted (>= 2)
// Ports:
//   clk    : clock, all state updates on posedge
//   rst    : asynchronous, active-high reset
//   btn_in : raw button, asynchronous to clk, may bounce
//   db_out : debounced level, registered
//   pulse  : one-cycle strobe per accepted press, registered
// ---------------------------------------------------------------------------
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic db_out,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

  logic             sync;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             pulse_q, pulse_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync)
  );

  // A reversal of sync is checked before the terminal count so that a bounce
  // on the very last wait cycle still aborts the transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      ZERO: begin
        if (sync) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!sync) begin
          state_d = ZERO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = ONE;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ONE: begin
        if (!sync) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (sync) begin
          state_d = ONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = ZERO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
    // Output is derived from the next state so it changes on the same edge
    // as the state it reflects.
    db_d = (state_d == ONE) || (state_d == WAIT0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ZERO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      pulse_q <= pulse_d;
    end
  end

  assign db_out = db_q;
  assign pulse  = pulse_q;

endmodule : debounce_pulse
